// File: rtl/pri_frame_if.sv
// Sample stream in from the Aurora receiver and the framed stream out to DPC.
interface pri_frame_if #(
    parameter int DATA_W = 36
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              dpc_start;
    logic [DATA_W-1:0] dpc_data;
    logic              dpc_valid;
    logic              dpc_last;
    logic              dpc_abort;

    modport master (
        output rx_data, rx_valid,
        input  dpc_start, dpc_data, dpc_valid, dpc_last, dpc_abort
    );

    modport slave (
        input  rx_data, rx_valid,
        output dpc_start, dpc_data, dpc_valid, dpc_last, dpc_abort
    );
endinterface

// File: rtl/pri_frame_ctrl.sv
// PRI-synchronous frame sequencer: skips cfg_skip samples after each accepted
// PRI edge, forwards cfg_len samples to DPC, and counts link/overrun/stall errors.
module pri_frame_ctrl #(
    parameter int DATA_W  = 36,
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk_200M,
    input  logic             rst,
    input  logic             PRI,
    input  logic             channel_up,
    input  logic [LEN_W-1:0] cfg_skip,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             err_clr,
    pri_frame_if.slave       bus,
    output logic             frame_done,
    output logic             busy,
    output logic [LEN_W-1:0] cnt_srio,
    output logic [31:0]      frame_cnt,
    output logic [15:0]      err_link,
    output logic [15:0]      err_overrun,
    output logic [15:0]      err_timeout
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SKIP    = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    logic [1:0]        r_state;
    logic              r_pri_d;
    logic [LEN_W-1:0]  r_skip, r_len, r_skip_cnt, r_cnt;
    logic [IDLE_W-1:0] r_idle_cnt;
    logic [DATA_W-1:0] r_data;
    logic              r_start, r_valid, r_last, r_abort, r_done;
    logic [31:0]       r_frame_cnt;
    logic [15:0]       r_err_link, r_err_overrun, r_err_timeout;

    logic w_busy, w_pri_edge, w_start, w_link_inc, w_ovr_inc, w_to_hit;

    always_comb begin
        w_busy     = (r_state == ST_SKIP) || (r_state == ST_CAPTURE);
        w_pri_edge = PRI & ~r_pri_d;
        w_start    = ~w_busy & w_pri_edge & channel_up & (cfg_len != '0);
        // Link loss is charged both for a dead-link edge and for a drop mid-window.
        w_link_inc = ~channel_up & (w_busy | w_pri_edge);
        w_ovr_inc  = w_busy & w_pri_edge;
        w_to_hit   = w_busy & channel_up & (r_idle_cnt == IDLE_W'(TIMEOUT));
    end

    always_ff @(posedge clk_200M) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pri_d     <= 1'b0;
            r_skip      <= '0;
            r_len       <= '0;
            r_skip_cnt  <= '0;
            r_cnt       <= '0;
            r_data      <= '0;
            r_start     <= 1'b0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_abort     <= 1'b0;
            r_done      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_pri_d <= PRI;
            r_start <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_abort <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                ST_SKIP, ST_CAPTURE: begin
                    if (!channel_up || w_to_hit) begin
                        r_abort <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (bus.rx_valid) begin
                        if (r_state == ST_SKIP) begin
                            r_skip_cnt <= r_skip_cnt + LEN_W'(1);
                            if (r_skip_cnt == r_skip - LEN_W'(1))
                                r_state <= ST_CAPTURE;
                        end else begin
                            r_data  <= bus.rx_data;
                            r_valid <= 1'b1;
                            r_cnt   <= r_cnt + LEN_W'(1);
                            if (r_cnt + LEN_W'(1) == r_len) begin
                                r_last      <= 1'b1;
                                r_done      <= 1'b1;
                                r_frame_cnt <= r_frame_cnt + 32'd1;
                                r_state     <= ST_DONE;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    if (w_start) begin
                        r_start    <= 1'b1;
                        r_cnt      <= '0;
                        r_skip     <= cfg_skip;
                        r_len      <= cfg_len;
                        r_skip_cnt <= '0;
                        r_state    <= (cfg_skip == '0) ? ST_CAPTURE : ST_SKIP;
                    end
                end
            endcase
        end
    end

    // Stall detector: counts idle cycles inside a window, parks at TIMEOUT.
    always_ff @(posedge clk_200M) begin
        if (rst || w_start || bus.rx_valid)
            r_idle_cnt <= '0;
        else if (w_busy && r_idle_cnt != IDLE_W'(TIMEOUT))
            r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
    end

    always_ff @(posedge clk_200M) begin
        if (rst || err_clr) begin
            r_err_link    <= '0;
            r_err_overrun <= '0;
            r_err_timeout <= '0;
        end else begin
            if (w_link_inc && r_err_link != 16'hFFFF)
                r_err_link <= r_err_link + 16'd1;
            if (w_ovr_inc && r_err_overrun != 16'hFFFF)
                r_err_overrun <= r_err_overrun + 16'd1;
            if (w_to_hit && r_err_timeout != 16'hFFFF)
                r_err_timeout <= r_err_timeout + 16'd1;
        end
    end

    assign bus.dpc_start = r_start;
    assign bus.dpc_data  = r_data;
    assign bus.dpc_valid = r_valid;
    assign bus.dpc_last  = r_last;
    assign bus.dpc_abort = r_abort;
    assign frame_done    = r_done;
    assign busy          = w_busy;
    assign cnt_srio      = r_cnt;
    assign frame_cnt     = r_frame_cnt;
    assign err_link      = r_err_link;
    assign err_overrun   = r_err_overrun;
    assign err_timeout   = r_err_timeout;
endmodule
